mcu_packet_scheduler: RTL and testbench



---
 rtl/mcu_packet_scheduler.sv | 168 ++++++++++++++++
 tb/tb_mcu_packet_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_packet_scheduler.sv
// rtl/mcu_packet_scheduler.sv - double-buffered sensor packet publisher for the MCU SPI slave
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   cs_n           raw MCU chip select (asynchronous, active low)
//   pkt_valid      one-cycle strobe, pkt_in holds a complete packet
//   pkt_in         incoming packet, byte 0 is the header
//   pkt_out        front buffer feeding the SPI slave shifter
//   data_ready     high while the front buffer holds an unread packet
//   seq_num        sequence number of the current front packet
//   overrun_count  saturating count of lost packets
//   bad_hdr_count  saturating count of packets dropped for a bad header
//
// Build option: MCU_TEST_PATTERN_EN loads a fixed pattern (AA,11,22,...,DD)
// into the back buffer on every good packet instead of pkt_in bytes 1-15.

module mcu_packet_scheduler #(
    parameter int         PACKET_SIZE   = 16,
    parameter logic [7:0] HEADER_BYTE   = 8'hAA,
    parameter int         SETTLE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cs_n,
    input  logic                        pkt_valid,
    input  logic [PACKET_SIZE-1:0][7:0] pkt_in,
    output logic [PACKET_SIZE-1:0][7:0] pkt_out,
    output logic                        data_ready,
    output logic [15:0]                 seq_num,
    output logic [7:0]                  overrun_count,
    output logic [7:0]                  bad_hdr_count
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, READY, XFER, SETTLE} state_t;

    state_t                      state, state_nx;
    logic                        cs_meta, cs_s, cs_prev;
    logic                        cs_fall, cs_rise;
    logic [PACKET_SIZE-1:0][7:0] back;
    logic [PACKET_SIZE-1:0][7:0] load_pkt;
    logic [PACKET_SIZE-1:0][7:0] swap_pkt;
    logic                        pending;
    logic [CW-1:0]               settle_cnt;
    logic                        good_pkt, bad_pkt;
    logic                        do_swap, clr_ready, load_settle, dec_settle;
    logic                        ovr_evt;
    logic [15:0]                 seq_next;

    assign cs_fall  = cs_prev & ~cs_s;
    assign cs_rise  = ~cs_prev & cs_s;
    assign good_pkt = pkt_valid && (pkt_in[0] == HEADER_BYTE);
    assign bad_pkt  = pkt_valid && (pkt_in[0] != HEADER_BYTE);
    assign seq_next = seq_num + 16'd1;

    // A swap that coincides with a new packet reads the old back buffer, so
    // the new packet is not lost and is not counted as an overrun.
    assign ovr_evt = (good_pkt && pending && !do_swap) || (do_swap && data_ready);

`ifdef MCU_TEST_PATTERN_EN
    always_comb begin
        load_pkt    = '0;
        load_pkt[0] = pkt_in[0];
        for (int k = 1; k < PACKET_SIZE; k++) begin
            load_pkt[k] = 8'(k * 17);
        end
    end
`else
    assign load_pkt = pkt_in;
`endif

    // The front packet carries its own sequence number, MSB first.
    always_comb begin
        swap_pkt                = back;
        swap_pkt[PACKET_SIZE-2] = seq_next[15:8];
        swap_pkt[PACKET_SIZE-1] = seq_next[7:0];
    end

    always_comb begin
        state_nx    = state;
        do_swap     = 1'b0;
        clr_ready   = 1'b0;
        load_settle = 1'b0;
        dec_settle  = 1'b0;
        case (state)
            IDLE, READY: begin
                // A starting transfer wins over a pending swap so the shifter
                // never sees the buffer change under an asserted chip select.
                if (cs_fall) begin
                    state_nx  = XFER;
                    clr_ready = 1'b1;
                end else if (pending) begin
                    state_nx = READY;
                    do_swap  = 1'b1;
                end
            end
            XFER: begin
                if (cs_rise) begin
                    state_nx    = SETTLE;
                    load_settle = 1'b1;
                end
            end
            SETTLE: begin
                if (cs_fall) begin
                    state_nx = XFER;
                end else if (settle_cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    dec_settle = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_meta       <= 1'b1;
            cs_s          <= 1'b1;
            cs_prev       <= 1'b1;
            state         <= IDLE;
            settle_cnt    <= '0;
            back          <= '0;
            pending       <= 1'b0;
            pkt_out       <= '0;
            data_ready    <= 1'b0;
            seq_num       <= 16'd0;
            overrun_count <= 8'd0;
            bad_hdr_count <= 8'd0;
        end else begin
            cs_meta <= cs_n;
            cs_s    <= cs_meta;
            cs_prev <= cs_s;
            state   <= state_nx;

            if (load_settle) begin
                settle_cnt <= CW'(SETTLE_CYCLES - 1);
            end else if (dec_settle) begin
                settle_cnt <= settle_cnt - 1'b1;
            end

            if (do_swap) begin
                pkt_out    <= swap_pkt;
                seq_num    <= seq_next;
                data_ready <= 1'b1;
            end else if (clr_ready) begin
                data_ready <= 1'b0;
            end

            if (good_pkt) begin
                back    <= load_pkt;
                pending <= 1'b1;
            end else if (do_swap) begin
                pending <= 1'b0;
            end

            if (bad_pkt && bad_hdr_count != 8'hFF) begin
                bad_hdr_count <= bad_hdr_count + 8'd1;
            end
            if (ovr_evt && overrun_count != 8'hFF) begin
                overrun_count <= overrun_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mcu_packet_scheduler.sv
// tb/tb_mcu_packet_scheduler.sv - scoreboard bench for mcu_packet_scheduler

module tb_mcu_packet_scheduler;

    localparam int SETTLE_CYCLES = 4;

    typedef logic [15:0][7:0] pkt_t;
    typedef struct {
        pkt_t        pkt;
        logic [15:0] seq;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_n;
    logic        pkt_valid;
    pkt_t        pkt_in;
    pkt_t        pkt_out;
    logic        data_ready;
    logic [15:0] seq_num;
    logic [7:0]  overrun_count;
    logic [7:0]  bad_hdr_count;

    mcu_packet_scheduler #(
        .PACKET_SIZE  (16),
        .HEADER_BYTE  (8'hAA),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cs_n         (cs_n),
        .pkt_valid    (pkt_valid),
        .pkt_in       (pkt_in),
        .pkt_out      (pkt_out),
        .data_ready   (data_ready),
        .seq_num      (seq_num),
        .overrun_count(overrun_count),
        .bad_hdr_count(bad_hdr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb_q[$];
    logic [15:0] last_seq = 16'd0;
    int          swap_cnt = 0;
    int          swap_cyc = 0;
    bit          sb_en = 1'b1;
    pkt_t        front = '0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to the next falling edge and observe any publish event there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!reset && seq_num !== last_seq) begin
            swap_cnt++;
            swap_cyc = cyc;
            if (sb_en) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_swap", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("front_pkt", pkt_out, e.pkt);
                    chk("front_seq", seq_num, e.seq);
                    front = e.pkt;
                end
            end
        end
        last_seq = seq_num;
    endtask

    function automatic pkt_t make_pkt(input logic [7:0] hdr, input logic [7:0] base);
        pkt_t p;
        p[0] = hdr;
        for (int k = 1; k < 16; k++) p[k] = base + 8'(k);
        return p;
    endfunction

    task automatic expect_front(input pkt_t p, input logic [15:0] s);
        exp_t e;
        e.pkt = p;
`ifdef MCU_TEST_PATTERN_EN
        for (int k = 1; k < 14; k++) e.pkt[k] = 8'(k * 17);
`endif
        e.pkt[14] = s[15:8];
        e.pkt[15] = s[7:0];
        e.seq = s;
        sb_q.push_back(e);
    endtask

    task automatic send(input pkt_t p);
        pkt_in    = p;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
    endtask

    task automatic wait_swap(input int start, input int limit, input string tag);
        for (int i = 0; i < limit; i++) begin
            if (swap_cnt != start) break;
            tick();
        end
        chk(tag, swap_cnt != start, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pkt_out"}, pkt_out, 0);
        chk({tag, "_data_ready"}, data_ready, 0);
        chk({tag, "_seq"}, seq_num, 0);
        chk({tag, "_overrun"}, overrun_count, 0);
        chk({tag, "_bad_hdr"}, bad_hdr_count, 0);
    endtask

    initial begin
        pkt_t p;
        int   s0;
        int   mark;

        reset     = 1'b1;
        cs_n      = 1'b1;
        pkt_valid = 1'b0;
        pkt_in    = '0;
        do_reset();
        chk_reset_state("rst");

        // One good packet: published on the edge after it is sampled.
        p = make_pkt(8'hAA, 8'h00);
        expect_front(p, 16'd1);
        s0   = swap_cnt;
        mark = cyc + 1;
        send(p);
        wait_swap(s0, 4, "t1_swap_seen");
        chk("t1_latency", swap_cyc, mark + 1);
        chk("t1_data_ready", data_ready, 1);

        // Bad header: counted and otherwise ignored.
        s0 = swap_cnt;
        send(make_pkt(8'h55, 8'h20));
        repeat (3) tick();
        chk("t2_bad_hdr", bad_hdr_count, 1);
        chk("t2_no_swap", swap_cnt, s0);
        chk("t2_front", pkt_out, front);
        chk("t2_data_ready", data_ready, 1);

        // Two packets during a long transfer: front frozen, second one wins.
        cs_n = 1'b0;
        repeat (10) tick();
        s0 = swap_cnt;
        send(make_pkt(8'hAA, 8'h30));
        repeat (4) tick();
        p = make_pkt(8'hAA, 8'h50);
        expect_front(p, 16'd2);
        send(p);
        repeat (184) tick();
        chk("t3_frozen", swap_cnt, s0);
        chk("t3_front", pkt_out, front);
        chk("t3_data_ready", data_ready, 0);
        chk("t3_overrun", overrun_count, 1);
        cs_n = 1'b1;
        mark = cyc + 1;
        wait_swap(s0, 20, "t3_swap_seen");
        chk("t3_settle_edges", swap_cyc - mark, SETTLE_CYCLES + 3);
        chk("t3_data_ready_after", data_ready, 1);
        chk("t3_overrun_after", overrun_count, 1);

        // Two packets 5 cycles apart with no CS activity.
        do_reset();
        s0 = swap_cnt;
        p = make_pkt(8'hAA, 8'h60);
        expect_front(p, 16'd1);
        send(p);
        repeat (4) tick();
        chk("t4_ready_between", data_ready, 1);
        p = make_pkt(8'hAA, 8'h70);
        expect_front(p, 16'd2);
        send(p);
        repeat (4) tick();
        chk("t4_swaps", swap_cnt - s0, 2);
        chk("t4_seq", seq_num, 2);
        chk("t4_overrun", overrun_count, 1);
        chk("t4_data_ready", data_ready, 1);

        // Drive seq_num to FFFF with back-to-back packets, then wrap.
        do_reset();
        sb_en     = 1'b0;
        pkt_in    = make_pkt(8'hAA, 8'h80);
        pkt_valid = 1'b1;
        repeat (65535) tick();
        pkt_valid = 1'b0;
        tick();
        tick();
        chk("t5_seq_max", seq_num, 16'hFFFF);
        chk("t5_overrun_sat", overrun_count, 8'hFF);
        sb_en = 1'b1;
        p = make_pkt(8'hAA, 8'h90);
        expect_front(p, 16'd0);
        s0 = swap_cnt;
        send(p);
        wait_swap(s0, 4, "t5_swap_seen");
        chk("t5_byte14", pkt_out[14], 8'h00);
        chk("t5_byte15", pkt_out[15], 8'h00);
        chk("t5_seq_wrap", seq_num, 16'h0000);

        // Reset with chip select held low.
        cs_n  = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        chk_reset_state("t6");
        reset = 1'b0;
        repeat (3) tick();
        s0 = swap_cnt;
        p = make_pkt(8'hAA, 8'hA0);
        expect_front(p, 16'd1);
        send(p);
        repeat (10) tick();
        chk("t6_held", swap_cnt, s0);
        chk("t6_data_ready", data_ready, 0);
        chk("t6_pkt_out", pkt_out, 0);
        cs_n = 1'b1;
        mark = cyc + 1;
        wait_swap(s0, 20, "t6_swap_seen");
        chk("t6_settle_edges", swap_cyc - mark, SETTLE_CYCLES + 3);
        chk("t6_data_ready_after", data_ready, 1);
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
